cc_decoder_write_pipe: RTL and testbench

- Registered, parametrised write-enable decoder for the general register file of the microprogrammed datapath.
- Arbitrates two write-back requesters onto the file's single write port:
  - port A: ALU result, strict priority, no backpressure;
  - port B: memory load, valid/ready handshake.
- Port B has a one-entry skid buffer that absorbs A/B collisions.
- Issued address is decoded to a one-hot write strobe, one cycle after acceptance. Register 0 is protected and invalid addresses are dropped.

---
 rtl/cc_decoder_write_pipe_if.sv | 32 +++
 rtl/cc_decoder_write_pipe.sv | 90 +++++++++
 tb/tb_cc_decoder_write_pipe.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/cc_decoder_write_pipe_if.sv
// Write-back request bus into the register-file write decoder: two requesters
// in, one-hot strobe and status out.
interface cc_decoder_write_pipe_if #(
  parameter int unsigned SEL_W = 6,
  parameter int unsigned OUT_W = 38
);
  logic             CC_DECODER_WRITE_PIPE_AValid_In;
  logic [SEL_W-1:0] CC_DECODER_WRITE_PIPE_ASelection_In;
  logic             CC_DECODER_WRITE_PIPE_BValid_In;
  logic [SEL_W-1:0] CC_DECODER_WRITE_PIPE_BSelection_In;
  logic             CC_DECODER_WRITE_PIPE_BReady_Out;
  logic [OUT_W-1:0] CC_DECODER_WRITE_PIPE_DataDecoder_Out;
  logic             CC_DECODER_WRITE_PIPE_Valid_Out;
  logic             CC_DECODER_WRITE_PIPE_Source_Out;
  logic             CC_DECODER_WRITE_PIPE_Drop_Out;

  modport master (
    output CC_DECODER_WRITE_PIPE_AValid_In, CC_DECODER_WRITE_PIPE_ASelection_In,
           CC_DECODER_WRITE_PIPE_BValid_In, CC_DECODER_WRITE_PIPE_BSelection_In,
    input  CC_DECODER_WRITE_PIPE_BReady_Out, CC_DECODER_WRITE_PIPE_DataDecoder_Out,
           CC_DECODER_WRITE_PIPE_Valid_Out, CC_DECODER_WRITE_PIPE_Source_Out,
           CC_DECODER_WRITE_PIPE_Drop_Out
  );

  modport slave (
    input  CC_DECODER_WRITE_PIPE_AValid_In, CC_DECODER_WRITE_PIPE_ASelection_In,
           CC_DECODER_WRITE_PIPE_BValid_In, CC_DECODER_WRITE_PIPE_BSelection_In,
    output CC_DECODER_WRITE_PIPE_BReady_Out, CC_DECODER_WRITE_PIPE_DataDecoder_Out,
           CC_DECODER_WRITE_PIPE_Valid_Out, CC_DECODER_WRITE_PIPE_Source_Out,
           CC_DECODER_WRITE_PIPE_Drop_Out
  );
endinterface

// File: rtl/cc_decoder_write_pipe.sv
// Register-file write-enable decoder: arbitrates ALU (A, priority) and load (B,
// handshake + one-entry skid) onto one write port, registered one-hot strobe.
module cc_decoder_write_pipe #(
  parameter int unsigned DATAWIDTH_DECODER_SELECTION = 6,
  parameter int unsigned DATAWIDTH_DECODER_OUT       = 38,
  parameter bit          ZERO_PROTECT                = 1'b1
) (
  input  logic                    CC_DECODER_WRITE_PIPE_CLOCK_50,
  input  logic                    CC_DECODER_WRITE_PIPE_RESET_InHigh,
  cc_decoder_write_pipe_if.slave  bus
);
  localparam int unsigned SEL_W = DATAWIDTH_DECODER_SELECTION;
  localparam int unsigned OUT_W = DATAWIDTH_DECODER_OUT;

  logic             buf_full;
  logic [SEL_W-1:0] buf_sel;

  logic             b_ready_c;
  logic             b_acc_c;
  logic             issue_c;
  logic             issue_src_c;
  logic [SEL_W-1:0] issue_sel_c;
  logic             legal_c;
  logic             buf_load_c;
  logic             buf_clear_c;
  logic [OUT_W-1:0] strobe_c;

  // B may only hand over a request while the skid slot is free and not in reset.
  assign b_ready_c = ~buf_full & ~CC_DECODER_WRITE_PIPE_RESET_InHigh;
  assign b_acc_c   = bus.CC_DECODER_WRITE_PIPE_BValid_In & b_ready_c;
  assign bus.CC_DECODER_WRITE_PIPE_BReady_Out = b_ready_c;

  // Issue selection: A first, then the parked B request, then a fresh B.
  always_comb begin
    issue_c     = 1'b0;
    issue_src_c = 1'b0;
    issue_sel_c = '0;
    buf_load_c  = 1'b0;
    buf_clear_c = 1'b0;
    if (bus.CC_DECODER_WRITE_PIPE_AValid_In) begin
      issue_c     = 1'b1;
      issue_sel_c = bus.CC_DECODER_WRITE_PIPE_ASelection_In;
      buf_load_c  = b_acc_c;
    end else if (buf_full) begin
      issue_c     = 1'b1;
      issue_src_c = 1'b1;
      issue_sel_c = buf_sel;
      buf_clear_c = 1'b1;
    end else if (b_acc_c) begin
      issue_c     = 1'b1;
      issue_src_c = 1'b1;
      issue_sel_c = bus.CC_DECODER_WRITE_PIPE_BSelection_In;
    end
  end

  // Out-of-range addresses and (optionally) the hardwired %r0 never write.
  always_comb begin
    legal_c  = (32'(issue_sel_c) < 32'(OUT_W)) &&
               !(ZERO_PROTECT && (issue_sel_c == '0));
    strobe_c = '0;
    for (int unsigned i = 0; i < OUT_W; i++) begin
      strobe_c[i] = issue_c && legal_c && (32'(issue_sel_c) == i);
    end
  end

  always_ff @(posedge CC_DECODER_WRITE_PIPE_CLOCK_50) begin
    if (CC_DECODER_WRITE_PIPE_RESET_InHigh) begin
      buf_full                              <= 1'b0;
      buf_sel                               <= '0;
      bus.CC_DECODER_WRITE_PIPE_DataDecoder_Out <= '0;
      bus.CC_DECODER_WRITE_PIPE_Valid_Out       <= 1'b0;
      bus.CC_DECODER_WRITE_PIPE_Source_Out      <= 1'b0;
      bus.CC_DECODER_WRITE_PIPE_Drop_Out        <= 1'b0;
    end else begin
      if (buf_load_c) begin
        buf_full <= 1'b1;
        buf_sel  <= bus.CC_DECODER_WRITE_PIPE_BSelection_In;
      end else if (buf_clear_c) begin
        buf_full <= 1'b0;
      end
      bus.CC_DECODER_WRITE_PIPE_DataDecoder_Out <= strobe_c;
      bus.CC_DECODER_WRITE_PIPE_Valid_Out       <= issue_c & legal_c;
      bus.CC_DECODER_WRITE_PIPE_Drop_Out        <= issue_c & ~legal_c;
      // Source keeps steering the data mux across idle cycles.
      if (issue_c) begin
        bus.CC_DECODER_WRITE_PIPE_Source_Out <= issue_src_c;
      end
    end
  end
endmodule

// File: tb/tb_cc_decoder_write_pipe.sv
// Bench for cc_decoder_write_pipe: directed vector table, reset-with-full-buffer
// sequence, then random traffic against a queue-based reference model.
module tb_cc_decoder_write_pipe;
  localparam int unsigned SW = 6;
  localparam int unsigned OW = 38;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cc_decoder_write_pipe_if #(.SEL_W(SW), .OUT_W(OW)) bus  ();
  cc_decoder_write_pipe_if #(.SEL_W(SW), .OUT_W(OW)) bus0 ();

  cc_decoder_write_pipe #(.DATAWIDTH_DECODER_SELECTION(SW), .DATAWIDTH_DECODER_OUT(OW),
                          .ZERO_PROTECT(1'b1)) dut (
    .CC_DECODER_WRITE_PIPE_CLOCK_50(clk), .CC_DECODER_WRITE_PIPE_RESET_InHigh(rst), .bus(bus));
  cc_decoder_write_pipe #(.DATAWIDTH_DECODER_SELECTION(SW), .DATAWIDTH_DECODER_OUT(OW),
                          .ZERO_PROTECT(1'b0)) dut0 (
    .CC_DECODER_WRITE_PIPE_CLOCK_50(clk), .CC_DECODER_WRITE_PIPE_RESET_InHigh(rst), .bus(bus0));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending B requests held in a queue of at most one entry.
  logic [SW-1:0] mq[$];
  logic          m_src = 1'b0;
  logic [OW-1:0] e_st, e_st0;
  logic          e_v, e_v0, e_d, e_d0;

  function automatic void decode(input logic [SW-1:0] s, input bit zp,
                                 output logic [OW-1:0] st, output logic v, output logic d);
    logic [63:0] w;
    w = 64'd1 << s;
    if (int'(s) >= int'(OW) || (zp && s == 0)) begin
      st = '0; v = 1'b0; d = 1'b1;
    end else begin
      st = w[OW-1:0]; v = 1'b1; d = 1'b0;
    end
  endfunction

  function automatic logic model_ready();
    return !rst && (mq.size() == 0);
  endfunction

  task automatic model_step(input logic r, input logic av, input logic [SW-1:0] as,
                            input logic bv, input logic [SW-1:0] bs);
    logic          b_acc, iss;
    logic [SW-1:0] s;
    b_acc = bv && (mq.size() == 0);
    iss = 1'b1;
    s = '0;
    if (r) begin
      mq.delete();
      m_src = 1'b0;
      iss = 1'b0;
    end else if (av) begin
      s = as; m_src = 1'b0;
      if (b_acc) mq.push_back(bs);
    end else if (mq.size() != 0) begin
      s = mq.pop_front(); m_src = 1'b1;
    end else if (b_acc) begin
      s = bs; m_src = 1'b1;
    end else begin
      iss = 1'b0;
    end
    if (iss) begin
      decode(s, 1'b1, e_st, e_v, e_d);
      decode(s, 1'b0, e_st0, e_v0, e_d0);
    end else begin
      e_st = '0; e_v = 1'b0; e_d = 1'b0;
      e_st0 = '0; e_v0 = 1'b0; e_d0 = 1'b0;
    end
  endtask

  task automatic drive(input logic r, input logic av, input logic [SW-1:0] as,
                       input logic bv, input logic [SW-1:0] bs);
    rst = r;
    bus.CC_DECODER_WRITE_PIPE_AValid_In      = av;
    bus.CC_DECODER_WRITE_PIPE_ASelection_In  = as;
    bus.CC_DECODER_WRITE_PIPE_BValid_In      = bv;
    bus.CC_DECODER_WRITE_PIPE_BSelection_In  = bs;
    bus0.CC_DECODER_WRITE_PIPE_AValid_In     = av;
    bus0.CC_DECODER_WRITE_PIPE_ASelection_In = as;
    bus0.CC_DECODER_WRITE_PIPE_BValid_In     = bv;
    bus0.CC_DECODER_WRITE_PIPE_BSelection_In = bs;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zp0_vs_model();
    chk("zp0_strobe", 64'(bus0.CC_DECODER_WRITE_PIPE_DataDecoder_Out), 64'(e_st0));
    chk("zp0_valid",  64'(bus0.CC_DECODER_WRITE_PIPE_Valid_Out),       64'(e_v0));
    chk("zp0_drop",   64'(bus0.CC_DECODER_WRITE_PIPE_Drop_Out),        64'(e_d0));
    chk("zp0_src",    64'(bus0.CC_DECODER_WRITE_PIPE_Source_Out),      64'(m_src));
  endtask

  task automatic check_invariants();
    chk("onehot", 64'($countones(bus.CC_DECODER_WRITE_PIPE_DataDecoder_Out) <= 1), 64'd1);
    chk("valid_nonzero", 64'(!bus.CC_DECODER_WRITE_PIPE_Valid_Out ||
                              (bus.CC_DECODER_WRITE_PIPE_DataDecoder_Out != '0)), 64'd1);
    chk("valid_drop_excl", 64'(bus.CC_DECODER_WRITE_PIPE_Valid_Out &&
                                bus.CC_DECODER_WRITE_PIPE_Drop_Out), 64'd0);
  endtask

  typedef struct {
    logic          r, av, bv;
    logic [SW-1:0] as, bs;
    logic          rdy;
    logic [OW-1:0] st;
    logic          v, src, d;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic av, input int as, input logic bv,
                              input int bs, input logic rdy, input logic [OW-1:0] st,
                              input logic v, input logic src, input logic d);
    vec_t x;
    x.r = r; x.av = av; x.as = SW'(as); x.bv = bv; x.bs = SW'(bs);
    x.rdy = rdy; x.st = st; x.v = v; x.src = src; x.d = d;
    return x;
  endfunction

  initial begin
    // Each row: inputs this cycle, BReady this cycle, outputs after the edge.
    vecs.push_back(mk(1, 0, 0, 0, 0,  0, 38'h0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 5, 1, 4,  0, 38'h0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,  1, 38'h0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 5, 0, 0,  1, 38'h20, 1, 0, 0));
    vecs.push_back(mk(0, 1, 3, 1, 7,  1, 38'h8, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 38'h80, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,  1, 38'h0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 1, 1, 9,  1, 38'h2, 1, 0, 0));
    vecs.push_back(mk(0, 1, 2, 1, 10, 0, 38'h4, 1, 0, 0));
    vecs.push_back(mk(0, 1, 4, 0, 0,  0, 38'h10, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 38'h200, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0,  1, 38'h0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 38, 0, 0, 1, 38'h0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 63, 0, 0, 1, 38'h0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0,  1, 38'h0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 20, 1, 38'h100000, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0,  1, 38'h0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0,  1, 38'h0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 37, 0, 0, 1, 38'h2000000000, 1, 0, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].av, vecs[i].as, vecs[i].bv, vecs[i].bs);
      chk($sformatf("vec%0d_bready", i), 64'(bus.CC_DECODER_WRITE_PIPE_BReady_Out), 64'(vecs[i].rdy));
      model_step(vecs[i].r, vecs[i].av, vecs[i].as, vecs[i].bv, vecs[i].bs);
      tick();
      chk($sformatf("vec%0d_strobe", i), 64'(bus.CC_DECODER_WRITE_PIPE_DataDecoder_Out), 64'(vecs[i].st));
      chk($sformatf("vec%0d_valid", i),  64'(bus.CC_DECODER_WRITE_PIPE_Valid_Out),       64'(vecs[i].v));
      chk($sformatf("vec%0d_src", i),    64'(bus.CC_DECODER_WRITE_PIPE_Source_Out),      64'(vecs[i].src));
      chk($sformatf("vec%0d_drop", i),   64'(bus.CC_DECODER_WRITE_PIPE_Drop_Out),        64'(vecs[i].d));
      check_zp0_vs_model();
      // Address 0 without protection must write bit 0.
      if (!vecs[i].r && vecs[i].av && vecs[i].as == 0) begin
        chk("zp0_addr0_strobe", 64'(bus0.CC_DECODER_WRITE_PIPE_DataDecoder_Out), 64'h1);
        chk("zp0_addr0_valid",  64'(bus0.CC_DECODER_WRITE_PIPE_Valid_Out),       64'h1);
      end
    end

    // Fill the skid slot with address 12, then reset: the entry must vanish.
    drive(0, 1, 6, 1, 12);
    model_step(0, 1, 6, 1, 12);
    tick();
    chk("fill_strobe", 64'(bus.CC_DECODER_WRITE_PIPE_DataDecoder_Out), 64'h40);
    drive(1, 0, 0, 0, 0);
    chk("fill_bready_low", 64'(bus.CC_DECODER_WRITE_PIPE_BReady_Out), 64'd0);
    model_step(1, 0, 0, 0, 0);
    tick();
    for (int k = 0; k < 6; k++) begin
      drive(0, 0, 0, 0, 0);
      chk("post_rst_bready", 64'(bus.CC_DECODER_WRITE_PIPE_BReady_Out), 64'd1);
      model_step(0, 0, 0, 0, 0);
      tick();
      chk("post_rst_no_r12", 64'(bus.CC_DECODER_WRITE_PIPE_DataDecoder_Out[12]), 64'd0);
      chk("post_rst_strobe", 64'(bus.CC_DECODER_WRITE_PIPE_DataDecoder_Out), 64'd0);
      chk("post_rst_drop",   64'(bus.CC_DECODER_WRITE_PIPE_Drop_Out), 64'd0);
    end

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic          r, av, bv;
      logic [SW-1:0] as, bs;
      r  = ($urandom % 64) == 0;
      av = ($urandom % 100) < 45;
      bv = ($urandom % 100) < 55;
      as = (($urandom % 4) == 0) ? SW'($urandom % 64) : SW'($urandom % OW);
      bs = (($urandom % 4) == 0) ? SW'($urandom % 64) : SW'($urandom % OW);
      drive(r, av, as, bv, bs);
      chk("rnd_bready", 64'(bus.CC_DECODER_WRITE_PIPE_BReady_Out), 64'(model_ready()));
      chk("rnd_bready0", 64'(bus0.CC_DECODER_WRITE_PIPE_BReady_Out), 64'(model_ready()));
      model_step(r, av, as, bv, bs);
      tick();
      chk("rnd_strobe", 64'(bus.CC_DECODER_WRITE_PIPE_DataDecoder_Out), 64'(e_st));
      chk("rnd_valid",  64'(bus.CC_DECODER_WRITE_PIPE_Valid_Out),       64'(e_v));
      chk("rnd_drop",   64'(bus.CC_DECODER_WRITE_PIPE_Drop_Out),        64'(e_d));
      chk("rnd_src",    64'(bus.CC_DECODER_WRITE_PIPE_Source_Out),      64'(m_src));
      check_zp0_vs_model();
      check_invariants();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
